abl: RTL and testbench

//  - Address Bus Low stage of the 65C02 address path. Computes next ADL from a selected base plus offset.
//  - Registers ABL, registers carry-out CO, and holds PCL.
//  - Drives the high-byte stage: CO feeds its CI (page carry, one cycle later), inc_pch feeds its inc_pc.
//  - Sits directly upstream of the ABH stage; op arrives from the microcode ROM the same cycle as the ABH op.

---
 rtl/abl_pkg.sv | 28 ++
 rtl/abl.sv | 121 ++++++++++++
 tb/tb_abl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/abl_pkg.sv
// ============================================================================
//  Module   : abl_pkg
//  Brief    : Field encodings for the Address Bus Low stage op word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package abl_pkg;

  // op[4:2] selects the adder base, op[1:0] selects the offset
  typedef logic [2:0] base_sel_t;
  typedef logic [1:0] ofs_sel_t;

  localparam base_sel_t BASE_ZERO = 3'b000;
  localparam base_sel_t BASE_ABL  = 3'b001;
  localparam base_sel_t BASE_PCL  = 3'b010;
  localparam base_sel_t BASE_DB   = 3'b011;
  localparam base_sel_t BASE_REG  = 3'b100;
  localparam base_sel_t BASE_S    = 3'b101;

  localparam ofs_sel_t OFS_0   = 2'b00;
  localparam ofs_sel_t OFS_1   = 2'b01;
  localparam ofs_sel_t OFS_REG = 2'b10;
  localparam ofs_sel_t OFS_M1  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/abl.sv
// ============================================================================
//  Module   : abl
//  Brief    : 65C02 Address Bus Low stage. Selects a base and an offset, adds
//             them into next ADL, registers ABL and the page carry CO, and
//             holds PCL. CO and inc_pch drive the high-byte stage.
//  Config   : ABL_SP_EN - internal stack pointer register S (written from ADL
//             on sp_wr). Undefined: S passes the external SP input through.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module abl
  import abl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] op,
  input  logic [7:0] DB,
  input  logic [7:0] REG,
  input  logic [7:0] SP,
  input  logic       sp_wr,
  input  logic       ld_pc,
  input  logic       inc_pc,
  output logic [7:0] ADL,
  output logic [7:0] ABL,
  output logic       CO,
  output logic [7:0] PCL,
  output logic       inc_pch,
  output logic [7:0] S
);

  base_sel_t  w_base_sel;
  ofs_sel_t   w_ofs_sel;
  logic [7:0] w_base;
  logic [7:0] w_ofs;
  logic [8:0] w_sum;
  logic [7:0] w_s;

  logic [7:0] r_abl;
  logic       r_co;
  logic [7:0] r_pcl;

  assign w_base_sel = op[4:2];
  assign w_ofs_sel  = op[1:0];

`ifdef ABL_SP_EN
  logic [7:0] r_s;
  logic [7:0] w_unused_sp;

  // SP is superseded by the internal register in this build
  assign w_unused_sp = SP;
  assign w_s         = r_s;

  // Stack pointer: written from the adder on the same edge as ABL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= 8'hFF;
    end else if (sp_wr) begin
      r_s <= w_sum[7:0];
    end
  end
`else
  logic w_unused_sp_wr;

  // Without the internal register there is nothing for sp_wr to write
  assign w_unused_sp_wr = sp_wr;
  assign w_s            = SP;
`endif

  // Base and offset selection; reserved base codes behave as ABL (hold)
  always_comb begin
    w_base = r_abl;
    case (w_base_sel)
      BASE_ZERO: w_base = 8'h00;
      BASE_ABL:  w_base = r_abl;
      BASE_PCL:  w_base = r_pcl;
      BASE_DB:   w_base = DB;
      BASE_REG:  w_base = REG;
      BASE_S:    w_base = w_s;
      default:   w_base = r_abl;
    endcase

    w_ofs = 8'h00;
    case (w_ofs_sel)
      OFS_0:   w_ofs = 8'h00;
      OFS_1:   w_ofs = 8'h01;
      OFS_REG: w_ofs = REG;
      OFS_M1:  w_ofs = 8'hFF;
      default: w_ofs = 8'h00;
    endcase
  end

  // 9-bit add; bit 8 is the page carry (for -1 it means "no borrow")
  assign w_sum = {1'b0, w_base} + {1'b0, w_ofs};

  // ABL/CO follow the adder every cycle; PCL loads from the registered ABL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abl <= 8'h00;
      r_co  <= 1'b0;
      r_pcl <= 8'h00;
    end else begin
      r_abl <= w_sum[7:0];
      r_co  <= w_sum[8];
      if (ld_pc) begin
        r_pcl <= r_abl + {7'd0, inc_pc};
      end
    end
  end

  assign ADL     = w_sum[7:0];
  assign ABL     = r_abl;
  assign CO      = r_co;
  assign PCL     = r_pcl;
  assign S       = w_s;
  // Not qualified by ld_pc: the high stage applies its own load enable
  assign inc_pch = inc_pc & (r_abl == 8'hFF);

endmodule

`default_nettype wire

// File: tb/tb_abl.sv
// ============================================================================
//  Module   : tb_abl
//  Brief    : Self-checking bench for abl: directed vector table, reset and
//             stack sequences, then randomized cycles against a model.
//  Config   : ABL_SP_EN - must match the build of the design under test.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] op;
  logic [7:0] DB, REG, SP;
  logic       sp_wr, ld_pc, inc_pc;
  logic [7:0] ADL, ABL, PCL, S;
  logic       CO, inc_pch;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  abl dut (
    .clk(clk), .rst(rst), .op(op), .DB(DB), .REG(REG), .SP(SP),
    .sp_wr(sp_wr), .ld_pc(ld_pc), .inc_pc(inc_pc),
    .ADL(ADL), .ABL(ABL), .CO(CO), .PCL(PCL), .inc_pch(inc_pch), .S(S)
  );

  typedef struct {
    logic [4:0] op;
    logic [7:0] db, rg, sp;
    logic       sp_wr, ld_pc, inc_pc;
    logic [7:0] adl;
    logic       inc_pch;
    logic [7:0] abl;
    logic       co;
    logic [7:0] pcl, s;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] o, input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] sp_v, input logic w, input logic l, input logic i);
    op = o; DB = d; REG = r; SP = sp_v; sp_wr = w; ld_pc = l; inc_pc = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [4:0] o, logic [7:0] d, logic [7:0] r, logic [7:0] sp_v,
                              logic w, logic l, logic i, logic [7:0] adl, logic ip,
                              logic [7:0] abl_e, logic co_e, logic [7:0] pcl_e, logic [7:0] s_e);
    vec_t v;
    v.op = o; v.db = d; v.rg = r; v.sp = sp_v; v.sp_wr = w; v.ld_pc = l; v.inc_pc = i;
    v.adl = adl; v.inc_pch = ip; v.abl = abl_e; v.co = co_e; v.pcl = pcl_e; v.s = s_e;
    return v;
  endfunction

  // reference model state
  int m_abl, m_co, m_pcl, m_s;

  initial begin
    rst = 1'b1;
    drive(5'b000_00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // ---- reset from a non-zero state, with loads requested during reset
    drive(5'b011_00, 8'h12, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'b011_00, 8'h37, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_reset_abl", {1'b0, ABL}, 9'h037);
    chk("pre_reset_pcl", {1'b0, PCL}, 9'h012);
    rst = 1'b1;
    drive(5'b011_10, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    chk("reset_abl", {1'b0, ABL}, 9'h000);
    chk("reset_pcl", {1'b0, PCL}, 9'h000);
    chk("reset_co",  {8'h00, CO}, 9'h000);
    chk("reset_s",   {1'b0, S},   9'h0FF);

    // ---- directed table; state continues from reset (ABL=00, PCL=00)
    //        op         DB     REG    SP     wr  ld  inc  ADL   ipch ABL   CO   PCL    S
    tbl.push_back(mk(5'b011_10, 8'hF0, 8'h20, 8'hFF, 0, 0, 0, 8'h10, 0, 8'h10, 1, 8'h00, 8'hFF)); // page cross
    tbl.push_back(mk(5'b001_00, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'h10, 0, 8'h10, 0, 8'h00, 8'hFF)); // hold clears CO
    tbl.push_back(mk(5'b000_00, 8'h55, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hFF)); // zero base
    tbl.push_back(mk(5'b001_11, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'hFF, 0, 8'hFF, 0, 8'h00, 8'hFF)); // 00-1 borrows
    tbl.push_back(mk(5'b001_00, 8'h00, 8'h00, 8'hFF, 0, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, 8'hFF)); // PC wrap
    tbl.push_back(mk(5'b011_00, 8'h7F, 8'h00, 8'hFF, 0, 0, 1, 8'h7F, 1, 8'h7F, 0, 8'h00, 8'hFF)); // inc_pch ungated
    tbl.push_back(mk(5'b001_00, 8'h00, 8'h00, 8'hFF, 0, 1, 1, 8'h7F, 0, 8'h7F, 0, 8'h80, 8'hFF)); // 7F+1
    tbl.push_back(mk(5'b011_00, 8'h05, 8'h00, 8'hFF, 0, 0, 0, 8'h05, 0, 8'h05, 0, 8'h80, 8'hFF));
    tbl.push_back(mk(5'b001_11, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'h04, 0, 8'h04, 1, 8'h80, 8'hFF)); // 05-1 no borrow
    tbl.push_back(mk(5'b011_00, 8'h40, 8'h00, 8'hFF, 0, 0, 0, 8'h40, 0, 8'h40, 0, 8'h80, 8'hFF));
    tbl.push_back(mk(5'b011_00, 8'h99, 8'h00, 8'hFF, 0, 1, 0, 8'h99, 0, 8'h99, 0, 8'h40, 8'hFF)); // PCL takes old ABL
    tbl.push_back(mk(5'b010_01, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 8'h41, 0, 8'h41, 0, 8'h40, 8'hFF)); // PCL+1
    tbl.push_back(mk(5'b100_11, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 8'hFF)); // REG-1
    tbl.push_back(mk(5'b111_01, 8'hAA, 8'h00, 8'hFF, 0, 0, 0, 8'h01, 0, 8'h01, 0, 8'h40, 8'hFF)); // reserved = ABL
    tbl.push_back(mk(5'b110_10, 8'hAA, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 8'hFF)); // reserved + REG
`ifdef ABL_SP_EN
    tbl.push_back(mk(5'b101_11, 8'h00, 8'h00, 8'h3C, 1, 0, 0, 8'hFE, 0, 8'hFE, 1, 8'h40, 8'hFE)); // push
    tbl.push_back(mk(5'b101_01, 8'h00, 8'h00, 8'h3C, 1, 0, 0, 8'hFF, 0, 8'hFF, 0, 8'h40, 8'hFF)); // pop
    tbl.push_back(mk(5'b101_01, 8'h00, 8'h00, 8'h3C, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 8'hFF)); // no sp_wr
`else
    tbl.push_back(mk(5'b101_00, 8'h00, 8'h00, 8'hC3, 1, 0, 0, 8'hC3, 0, 8'hC3, 0, 8'h40, 8'hC3)); // SP passthrough
    tbl.push_back(mk(5'b101_01, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 8'hFF));
`endif

    foreach (tbl[k]) begin
      drive(tbl[k].op, tbl[k].db, tbl[k].rg, tbl[k].sp, tbl[k].sp_wr, tbl[k].ld_pc, tbl[k].inc_pc);
      #2;
      chk($sformatf("v%0d_adl", k),     {1'b0, ADL},     {1'b0, tbl[k].adl});
      chk($sformatf("v%0d_inc_pch", k), {8'h00, inc_pch}, {8'h00, tbl[k].inc_pch});
      tick();
      chk($sformatf("v%0d_abl", k), {1'b0, ABL},  {1'b0, tbl[k].abl});
      chk($sformatf("v%0d_co", k),  {8'h00, CO},  {8'h00, tbl[k].co});
      chk($sformatf("v%0d_pcl", k), {1'b0, PCL},  {1'b0, tbl[k].pcl});
      chk($sformatf("v%0d_s", k),   {1'b0, S},    {1'b0, tbl[k].s});
    end

    // ---- randomized cycles against the arithmetic model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_abl = 0; m_co = 0; m_pcl = 0; m_s = 255;
    for (int n = 0; n < 400; n++) begin
      int base, ofs, sum, s_cur;
      logic r;
      r = ($urandom_range(0, 31) == 0);
      rst = r;
      drive(5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
`ifdef ABL_SP_EN
      s_cur = m_s;
`else
      s_cur = int'(SP);
`endif
      case (int'(op) / 4)
        0:       base = 0;
        1:       base = m_abl;
        2:       base = m_pcl;
        3:       base = int'(DB);
        4:       base = int'(REG);
        5:       base = s_cur;
        default: base = m_abl;
      endcase
      case (int'(op) % 4)
        0:       ofs = 0;
        1:       ofs = 1;
        2:       ofs = int'(REG);
        default: ofs = 255;
      endcase
      sum = base + ofs;
      #2;
      chk("rnd_adl",     {1'b0, ADL},      9'(sum % 256));
      chk("rnd_inc_pch", {8'h00, inc_pch}, 9'((inc_pc && m_abl == 255) ? 1 : 0));
      chk("rnd_s_comb",  {1'b0, S},        9'(s_cur));
      if (r) begin
        m_abl = 0; m_co = 0; m_pcl = 0; m_s = 255;
      end else begin
        if (ld_pc) m_pcl = (m_abl + int'(inc_pc)) % 256;
`ifdef ABL_SP_EN
        if (sp_wr) m_s = sum % 256;
`endif
        m_abl = sum % 256;
        m_co  = (sum >= 256) ? 1 : 0;
      end
      tick();
      rst = 1'b0;
      chk("rnd_abl", {1'b0, ABL}, 9'(m_abl));
      chk("rnd_co",  {8'h00, CO}, 9'(m_co));
      chk("rnd_pcl", {1'b0, PCL}, 9'(m_pcl));
`ifdef ABL_SP_EN
      chk("rnd_s",   {1'b0, S},   9'(m_s));
`else
      chk("rnd_s",   {1'b0, S},   {1'b0, SP});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
